// File: rtl/store_byte_lane_aligner_pkg.sv
// Shared types and helpers for the store-side byte-lane aligner.
//   store_size_t : encoding of the 2-bit store size field
//   NUM_BANKS    : number of 8-bit sub-RAM banks behind the 32-bit word
//   base_mask()  : unrotated byte-lane mask for a given store size
package mem_store_pkg;

   localparam int unsigned NUM_BANKS = 4;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } store_size_t;

   // Lane mask before rotation; reserved size writes nothing.
   function automatic logic [NUM_BANKS-1:0] base_mask(input store_size_t sz);
      logic [NUM_BANKS-1:0] m;
      case (sz)
         SZ_BYTE: m = 4'b0001;
         SZ_HALF: m = 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/store_byte_lane_aligner_rotator.sv
// byte_rotator_left: combinational four-byte left rotator.
// Mirror of the load-side right rotator; byte k of din lands in byte (k+shamt) mod 4.
//   din    : 32-bit input word
//   shamt  : rotate amount in bytes
//   dout   : rotated word
module byte_rotator_left (
   input  logic [31:0] din,
   input  logic [1:0]  shamt,
   output logic [31:0] dout
);

   always_comb begin
      dout = din;
      case (shamt)
         2'd0: dout = din;
         2'd1: dout = {din[23:0], din[31:24]};
         2'd2: dout = {din[15:0], din[31:16]};
         2'd3: dout = {din[7:0],  din[31:8]};
         default: dout = din;
      endcase
   end

endmodule

// File: rtl/store_byte_lane_aligner.sv
// store_byte_lane_aligner: maps byte/halfword/word stores at any byte address onto
// four 8-bit sub-RAM banks in a single registered, stall-aware stage.
// Misaligned stores that cross a word row write row+1 in the low banks.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word stores are suppressed
// (mask 0000), flagged on misalign_err, acked but not counted.
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/req_ready          store request handshake
//   req_addr, req_data, req_size byte address, right-justified data, size code
//   mem_stall                    RAM side holds the current write
//   bank_we                      per-bank write enable
//   bank_addr_0..3, bank_data_0..3  per-bank row address and byte
//   store_ack                    pulse on commit
//   misalign_err                 (MISALIGN_TRAP_EN only) trapped entry pending
//   store_count                  committed-store counter, wraps
module store_byte_lane_aligner
   import mem_store_pkg::*;
#(
   parameter int unsigned ADDR_W  = 18,
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [ADDR_W-1:0]  req_addr,
   input  logic [31:0]        req_data,
   input  logic [1:0]         req_size,
   input  logic               mem_stall,
   output logic [3:0]         bank_we,
   output logic [ADDR_W-3:0]  bank_addr_0,
   output logic [ADDR_W-3:0]  bank_addr_1,
   output logic [ADDR_W-3:0]  bank_addr_2,
   output logic [ADDR_W-3:0]  bank_addr_3,
   output logic [7:0]         bank_data_0,
   output logic [7:0]         bank_data_1,
   output logic [7:0]         bank_data_2,
   output logic [7:0]         bank_data_3,
   output logic               store_ack,
`ifdef MISALIGN_TRAP_EN
   output logic               misalign_err,
`endif
   output logic [COUNT_W-1:0] store_count
);

   localparam int unsigned ROW_W = ADDR_W - 2;

   logic [1:0]           off;
   logic [ROW_W-1:0]     row;
   store_size_t          size;
   logic [7:0]           mask_dup;
   logic [3:0]           mask_d;
   logic [ROW_W-1:0]     row_d [NUM_BANKS];
   logic [31:0]          data_d;

   logic                 out_valid;
   logic [3:0]           we_q;
   logic [ROW_W-1:0]     addr_q [NUM_BANKS];
   logic [31:0]          data_q;
   logic [COUNT_W-1:0]   count_q;
   logic                 accept;
   logic                 commit;
`ifdef MISALIGN_TRAP_EN
   logic                 trap_d;
   logic                 trap_q;
`endif

   // Data path: rotate store bytes onto their banks.
   byte_rotator_left u_rot (
      .din   (req_data),
      .shamt (off),
      .dout  (data_d)
   );

   // Request decode: lane mask and per-bank row.
   always_comb begin
      off      = req_addr[1:0];
      row      = req_addr[ADDR_W-1:2];
      size     = store_size_t'(req_size);
      // Rotate-left of a 4-bit mask taken from the upper half of a doubled shift.
      mask_dup = {base_mask(size), base_mask(size)} << off;
      mask_d   = mask_dup[7:4];
`ifdef MISALIGN_TRAP_EN
      trap_d = ((size == SZ_HALF) && (off == 2'd3)) ||
               ((size == SZ_WORD) && (off != 2'd0));
      if (trap_d) begin
         mask_d = 4'b0000;
      end
`endif
      // Banks below the offset hold the bytes that spilled into the next row.
      for (int i = 0; i < NUM_BANKS; i++) begin
         row_d[i] = (2'(i) < off) ? row + ROW_W'(1) : row;
      end
   end

   assign req_ready = !out_valid || !mem_stall;
   assign commit    = out_valid && !mem_stall;
   assign accept    = req_valid && req_ready;
   assign store_ack = commit;

   // Output stage: load on accept, clear on a commit with nothing behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         we_q      <= 4'b0000;
         data_q    <= 32'h0;
         count_q   <= '0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            addr_q[i] <= '0;
         end
`ifdef MISALIGN_TRAP_EN
         trap_q    <= 1'b0;
`endif
      end else begin
`ifdef MISALIGN_TRAP_EN
         if (commit && !trap_q) begin
            count_q <= count_q + COUNT_W'(1);
         end
`else
         if (commit) begin
            count_q <= count_q + COUNT_W'(1);
         end
`endif
         if (accept) begin
            out_valid <= 1'b1;
            we_q      <= mask_d;
            data_q    <= data_d;
            for (int i = 0; i < NUM_BANKS; i++) begin
               addr_q[i] <= row_d[i];
            end
`ifdef MISALIGN_TRAP_EN
            trap_q    <= trap_d;
`endif
         end else if (commit) begin
            out_valid <= 1'b0;
            we_q      <= 4'b0000;
`ifdef MISALIGN_TRAP_EN
            trap_q    <= 1'b0;
`endif
         end
      end
   end

   // we_q is zeroed whenever out_valid drops, so it drives the enables directly.
   assign bank_we     = we_q;
   assign bank_addr_0 = addr_q[0];
   assign bank_addr_1 = addr_q[1];
   assign bank_addr_2 = addr_q[2];
   assign bank_addr_3 = addr_q[3];
   assign bank_data_0 = data_q[7:0];
   assign bank_data_1 = data_q[15:8];
   assign bank_data_2 = data_q[23:16];
   assign bank_data_3 = data_q[31:24];
   assign store_count = count_q;
`ifdef MISALIGN_TRAP_EN
   assign misalign_err = trap_q;
`endif

endmodule

// File: tb/tb_store_byte_lane_aligner.sv
// Testbench for store_byte_lane_aligner: directed stores with literal expectations,
// plus a per-cycle comparison against a byte-level model of the store path.
module tb_store_byte_lane_aligner;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [17:0] req_addr;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        mem_stall;
   logic [3:0]  bank_we;
   logic [15:0] bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3;
   logic [7:0]  bank_data_0, bank_data_1, bank_data_2, bank_data_3;
   logic        store_ack;
   logic [15:0] store_count;
`ifdef MISALIGN_TRAP_EN
   logic        misalign_err;
`endif

   int n_pass  = 0;
   int n_check = 0;

   store_byte_lane_aligner dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .req_size    (req_size),
      .mem_stall   (mem_stall),
      .bank_we     (bank_we),
      .bank_addr_0 (bank_addr_0),
      .bank_addr_1 (bank_addr_1),
      .bank_addr_2 (bank_addr_2),
      .bank_addr_3 (bank_addr_3),
      .bank_data_0 (bank_data_0),
      .bank_data_1 (bank_data_1),
      .bank_data_2 (bank_data_2),
      .bank_data_3 (bank_data_3),
      .store_ack   (store_ack),
`ifdef MISALIGN_TRAP_EN
      .misalign_err(misalign_err),
`endif
      .store_count (store_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_check++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- model: one pending store, described byte by byte ----------------
   logic        m_valid;
   logic        m_trap;
   logic [3:0]  m_mask;
   logic [15:0] m_addr [4];
   logic [7:0]  m_data [4];
   int          m_count;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 1'b0;
         m_trap  = 1'b0;
         m_mask  = 4'b0;
         m_count = 0;
      end else begin
         bit commit_now, accept_now;
         commit_now = m_valid && !mem_stall;
         accept_now = req_valid && (!m_valid || !mem_stall);
         if (commit_now && !m_trap) m_count = (m_count + 1) % 65536;
         if (accept_now) begin
            int nbytes, off, row;
            off    = int'(req_addr) % 4;
            row    = int'(req_addr) / 4;
            nbytes = (req_size == 2'd0) ? 1 : (req_size == 2'd1) ? 2 : (req_size == 2'd2) ? 4 : 0;
            m_mask = 4'b0;
            for (int k = 0; k < 4; k++) begin
               m_data[(k + off) % 4] = req_data[8*k +: 8];
               if (k < nbytes) m_mask[(k + off) % 4] = 1'b1;
            end
            for (int b = 0; b < 4; b++) m_addr[b] = 16'((row + ((b < off) ? 1 : 0)) % 65536);
            m_trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
            if ((nbytes == 2 && off == 3) || (nbytes == 4 && off != 0)) begin
               m_trap = 1'b1;
               m_mask = 4'b0;
            end
`endif
            m_valid = 1'b1;
         end else if (commit_now) begin
            m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      logic [15:0] act_addr [4];
      logic [7:0]  act_data [4];
      act_addr = '{bank_addr_0, bank_addr_1, bank_addr_2, bank_addr_3};
      act_data = '{bank_data_0, bank_data_1, bank_data_2, bank_data_3};
      chk("m_bank_we",   32'(bank_we),    32'(m_valid ? m_mask : 4'b0));
      chk("m_req_ready", 32'(req_ready),  32'(!m_valid || !mem_stall));
      chk("m_store_ack", 32'(store_ack),  32'(m_valid && !mem_stall));
      chk("m_count",     32'(store_count), 32'(m_count));
`ifdef MISALIGN_TRAP_EN
      chk("m_misalign",  32'(misalign_err), 32'(m_valid && m_trap));
`endif
      if (m_valid) begin
         for (int b = 0; b < 4; b++) begin
            chk($sformatf("m_addr%0d", b), 32'(act_addr[b]), 32'(m_addr[b]));
            chk($sformatf("m_data%0d", b), 32'(act_data[b]), 32'(m_data[b]));
         end
      end
   end

   // Present one request for a single edge, then stop at the following negedge.
   task automatic send(input logic [17:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic st);
      @(posedge clk); #1;
      req_valid = 1'b1; req_addr = a; req_data = d; req_size = s; mem_stall = st;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic settle();
      @(posedge clk); #1;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_stall = 1'b0;
      #12;
      chk("rst_we", 32'(bank_we), 32'h0);
      chk("rst_addr0", 32'(bank_addr_0), 32'h0);
      chk("rst_data3", 32'(bank_data_3), 32'h0);
      chk("rst_count", 32'(store_count), 32'h0);
      chk("rst_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1; rst = 1'b0;

      // Aligned word
      send(18'h00100, 32'hDDCCBBAA, 2'b10, 1'b0);
      chk("w_we", 32'(bank_we), 32'hF);
      chk("w_addr0", 32'(bank_addr_0), 32'h40);
      chk("w_addr3", 32'(bank_addr_3), 32'h40);
      chk("w_data", {bank_data_3, bank_data_2, bank_data_1, bank_data_0}, 32'hDDCCBBAA);
      chk("w_ack", 32'(store_ack), 32'h1);
      settle();
      chk("w_count", 32'(store_count), 32'h1);

      // Misaligned word crossing a row
      send(18'h00101, 32'hDDCCBBAA, 2'b10, 1'b0);
      chk("mw_we", 32'(bank_we), 32'hF);
      chk("mw_addr0", 32'(bank_addr_0), 32'h41);
      chk("mw_data0", 32'(bank_data_0), 32'hDD);
      chk("mw_addr1", 32'(bank_addr_1), 32'h40);
      chk("mw_data123", {8'h0, bank_data_3, bank_data_2, bank_data_1}, 32'h00CCBBAA);
      settle();

      // Crossing halfword with row wrap
      send(18'h3FFFF, 32'h00001122, 2'b01, 1'b0);
      chk("hw_we", 32'(bank_we), 32'h9);
      chk("hw_addr3", 32'(bank_addr_3), 32'hFFFF);
      chk("hw_data3", 32'(bank_data_3), 32'h22);
      chk("hw_addr0", 32'(bank_addr_0), 32'h0000);
      chk("hw_data0", 32'(bank_data_0), 32'h11);
      settle();

      // Byte with 3 stalled cycles
      send(18'h00002, 32'h0000005A, 2'b00, 1'b1);
      for (int c = 0; c < 3; c++) begin
         if (c > 0) settle();
         chk("st_we", 32'(bank_we), 32'h4);
         chk("st_data2", 32'(bank_data_2), 32'h5A);
         chk("st_ready", 32'(req_ready), 32'h0);
         chk("st_ack", 32'(store_ack), 32'h0);
      end
      @(posedge clk); #1; mem_stall = 1'b0;
      @(negedge clk);
      chk("st_ack_rel", 32'(store_ack), 32'h1);
      chk("st_we_rel", 32'(bank_we), 32'h4);
      settle();
      chk("st_count", 32'(store_count), 32'h4);

      // Back-to-back words
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         req_valid = 1'b1; req_addr = 18'(32'h10 + 4*i); req_data = 32'h01020304 * (i + 1);
         req_size = 2'b10;
         @(negedge clk);
         chk("b2b_ack", 32'(store_ack), 32'(i > 0));
      end
      @(posedge clk); #1; req_valid = 1'b0;
      @(negedge clk);
      chk("b2b_ack_last", 32'(store_ack), 32'h1);
      settle();
      chk("b2b_count", 32'(store_count), 32'h8);
      chk("b2b_idle_ack", 32'(store_ack), 32'h0);

      // Reserved size
      send(18'h00020, 32'h12345678, 2'b11, 1'b0);
      chk("rs_we", 32'(bank_we), 32'h0);
      chk("rs_ack", 32'(store_ack), 32'h1);
      settle();
      chk("rs_count", 32'(store_count), 32'h9);

      // Word at offset 2
      send(18'h00102, 32'h44332211, 2'b10, 1'b0);
`ifdef MISALIGN_TRAP_EN
      chk("tw_we", 32'(bank_we), 32'h0);
      chk("tw_err", 32'(misalign_err), 32'h1);
      chk("tw_ack", 32'(store_ack), 32'h1);
      settle();
      chk("tw_count", 32'(store_count), 32'h9);
`else
      chk("ow_we", 32'(bank_we), 32'hF);
      chk("ow_addr1", 32'(bank_addr_1), 32'h41);
      chk("ow_data1", 32'(bank_data_1), 32'h44);
      chk("ow_addr2", 32'(bank_addr_2), 32'h40);
      chk("ow_data2", 32'(bank_data_2), 32'h11);
      settle();
      chk("ow_count", 32'(store_count), 32'hA);
`endif

      // Async reset with a stalled store pending
      send(18'h00040, 32'hCAFEF00D, 2'b10, 1'b1);
      chk("ar_pending", 32'(bank_we), 32'hF);
      #1 rst = 1'b1;
      #1;
      chk("ar_we", 32'(bank_we), 32'h0);
      chk("ar_ack", 32'(store_ack), 32'h0);
      chk("ar_count", 32'(store_count), 32'h0);
      chk("ar_ready", 32'(req_ready), 32'h1);
      @(posedge clk); #1; rst = 1'b0; mem_stall = 1'b0;
      @(negedge clk);
      chk("ar_rel_ready", 32'(req_ready), 32'h1);
      chk("ar_rel_ack", 32'(store_ack), 32'h0);
      settle();

      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end

endmodule
